// File: rtl/btn_debounce_sync.sv
// btn_debounce_sync: tick-paced per-channel debouncer with level/press/release outputs.
// Optional auto-repeat strobes are built only when AUTO_REPEAT_EN is defined.
module btn_debounce_sync #(
    parameter int NUM_BTN      = 4,
    parameter int STABLE_TICKS = 8,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_in,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);
    typedef enum logic [1:0] {IDLE, ARM_PRESS, HELD, ARM_RELEASE} state_t;
    localparam logic [NUM_BTN-1:0] IDLE_PIN = {NUM_BTN{ACTIVE_LOW != 0}};
    localparam logic [7:0] STABLE = 8'(STABLE_TICKS);
    if (STABLE_TICKS < 1 || STABLE_TICKS > 255 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("btn_debounce_sync: parameter out of range");
    end
    logic [NUM_BTN-1:0] sync_1, sync_2, sync_n;
    // synchronisers start at the released pin value so reset release never looks like a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= IDLE_PIN;
            sync_2 <= IDLE_PIN;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end
    assign sync_n = sync_2 ^ IDLE_PIN;
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        state_t state, state_nx;
        logic [7:0] cnt, cnt_nx, cnt_inc;
        logic press_q, press_nx, release_q, release_nx;
        assign cnt_inc = (cnt == 8'hff) ? cnt : cnt + 8'd1;
        // a mismatch is tested before the tick, so it always wins over a count
        always_comb begin
            state_nx   = state;
            cnt_nx     = cnt;
            press_nx   = 1'b0;
            release_nx = 1'b0;
            case (state)
                IDLE: begin
                    state_nx = sync_n[i] ? ARM_PRESS : IDLE;
                    cnt_nx   = '0;
                end
                ARM_PRESS: begin
                    if (!sync_n[i]) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (tick_in) begin
                        press_nx = cnt_inc >= STABLE;
                        state_nx = press_nx ? HELD : ARM_PRESS;
                        cnt_nx   = press_nx ? 8'd0 : cnt_inc;
                    end
                end
                HELD: begin
                    state_nx = sync_n[i] ? HELD : ARM_RELEASE;
                    cnt_nx   = '0;
                end
                ARM_RELEASE: begin
                    if (sync_n[i]) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                    end else if (tick_in) begin
                        release_nx = cnt_inc >= STABLE;
                        state_nx   = release_nx ? IDLE : ARM_RELEASE;
                        cnt_nx     = release_nx ? 8'd0 : cnt_inc;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state     <= IDLE;
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nx;
                cnt       <= cnt_nx;
                press_q   <= press_nx;
                release_q <= release_nx;
            end
        end
        assign btn_level[i]   = (state == HELD) || (state == ARM_RELEASE);
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
`ifdef AUTO_REPEAT_EN
        logic [15:0] rep_cnt, rep_cnt_nx, rep_inc;
        logic rep_q, rep_nx;
        assign rep_inc = rep_cnt + 16'd1;
        // counts ticks spent settled in HELD; wraps back to REPEAT_DELAY after each periodic strobe
        always_comb begin
            rep_cnt_nx = '0;
            rep_nx     = 1'b0;
            if (state == HELD && sync_n[i]) begin
                rep_cnt_nx = rep_cnt;
                if (tick_in) begin
                    rep_nx     = (rep_inc == 16'(REPEAT_DELAY)) || (rep_inc == 16'(REPEAT_DELAY + REPEAT_RATE));
                    rep_cnt_nx = (rep_inc == 16'(REPEAT_DELAY + REPEAT_RATE)) ? 16'(REPEAT_DELAY) : rep_inc;
                end
            end
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rep_cnt <= '0;
                rep_q   <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt_nx;
                rep_q   <= rep_nx;
            end
        end
        assign btn_repeat[i] = rep_q;
`else
        assign btn_repeat[i] = 1'b0;
`endif
    end
endmodule
